// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage.
//   - ALU function codes (aluop)
//   - HI/LO unit function codes (md_func)
//   - Field positions of the 38-bit MEM/WB back-bus {we, rw[4:0], data[31:0]}
//   - Divide helper used by the HI/LO unit
package ex_pkg;

  localparam int BACK_W       = 38;
  localparam int BACK_WE_BIT  = 37;
  localparam int BACK_RW_HI   = 36;
  localparam int BACK_RW_LO   = 32;
  localparam int BACK_DATA_HI = 31;
  localparam int BACK_DATA_LO = 0;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_SLLV = 4'd11,
    ALU_SRLV = 4'd12,
    ALU_SRAV = 4'd13,
    ALU_LUI  = 4'd14,
    ALU_PASS = 4'd15
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_NONE = 3'd0,
    MD_MULT = 3'd1,
    MD_DIV  = 3'd2,
    MD_MTHI = 3'd3,
    MD_MTLO = 3'd4
  } md_func_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  // Divide a by b. Signed mode truncates toward zero and gives the remainder
  // the dividend's sign. Divide-by-zero and the single signed overflow case
  // return fixed values instead of relying on the divider.
  function automatic md_res_t div_op(input logic [31:0] a, input logic [31:0] b,
                                     input logic sgn);
    md_res_t     res;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic        neg_q;
    logic        neg_r;
    res   = '0;
    abs_a = 32'd0;
    abs_b = 32'd0;
    q_mag = 32'd0;
    r_mag = 32'd0;
    neg_q = 1'b0;
    neg_r = 1'b0;
    if (b == 32'd0) begin
      res.lo = 32'hFFFF_FFFF;
      res.hi = a;
    end else if (sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      res.lo = 32'h8000_0000;
      res.hi = 32'd0;
    end else begin
      neg_q = sgn & (a[31] ^ b[31]);
      neg_r = sgn & a[31];
      // 0x80000000 negates to itself, which is the correct unsigned magnitude
      abs_a = (sgn && a[31]) ? (~a + 32'd1) : a;
      abs_b = (sgn && b[31]) ? (~b + 32'd1) : b;
      q_mag = abs_a / abs_b;
      r_mag = abs_a % abs_b;
      res.lo = neg_q ? (~q_mag + 32'd1) : q_mag;
      res.hi = neg_r ? (~r_mag + 32'd1) : r_mag;
    end
    return res;
  endfunction

endpackage

// File: rtl/ex_alu.sv
// ex_alu: combinational 32-bit ALU.
//   a, b  : operands
//   sa    : immediate shift amount
//   aluop : function (see ex_pkg::alu_op_e)
//   c     : result, zero : c == 0
module ex_alu
  import ex_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  sa,
  input  logic [3:0]  aluop,
  output logic [31:0] c,
  output logic        zero
);

  // Function decode; all arithmetic wraps modulo 2^32.
  always_comb begin
    c = 32'd0;
    case (aluop)
      ALU_ADD:  c = a + b;
      ALU_SUB:  c = a - b;
      ALU_AND:  c = a & b;
      ALU_OR:   c = a | b;
      ALU_XOR:  c = a ^ b;
      ALU_NOR:  c = ~(a | b);
      ALU_SLT:  c = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: c = (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  c = b << sa;
      ALU_SRL:  c = b >> sa;
      ALU_SRA:  c = $unsigned($signed(b) >>> sa);
      ALU_SLLV: c = b << a[4:0];
      ALU_SRLV: c = b >> a[4:0];
      ALU_SRAV: c = $unsigned($signed(b) >>> a[4:0]);
      ALU_LUI:  c = {b[15:0], 16'h0000};
      ALU_PASS: c = b;
      default:  c = 32'd0;
    endcase
  end

  assign zero = (c == 32'd0);

endmodule

// File: rtl/ex_forward.sv
// ex_forward: operand bypass for one source register.
//   reg_num   : source register number
//   rd        : register-file read data
//   mem_back  : MEM-stage back-bus, use_mem enables it
//   wb_back   : WB-stage back-bus, use_wb enables it
//   fwd       : forwarded operand (MEM has priority over WB, r0 never forwarded)
module ex_forward
  import ex_pkg::*;
(
  input  logic [4:0]        reg_num,
  input  logic [31:0]       rd,
  input  logic [BACK_W-1:0] mem_back,
  input  logic              use_mem,
  input  logic [BACK_W-1:0] wb_back,
  input  logic              use_wb,
  output logic [31:0]       fwd
);

  logic hit_mem_s;
  logic hit_wb_s;

  assign hit_mem_s = use_mem && mem_back[BACK_WE_BIT] &&
                     (mem_back[BACK_RW_HI:BACK_RW_LO] == reg_num) && (reg_num != 5'd0);
  assign hit_wb_s  = use_wb && wb_back[BACK_WE_BIT] &&
                     (wb_back[BACK_RW_HI:BACK_RW_LO] == reg_num) && (reg_num != 5'd0);

  // Priority select: younger MEM result wins over WB, else register file.
  always_comb begin
    fwd = rd;
    if (hit_mem_s) begin
      fwd = mem_back[BACK_DATA_HI:BACK_DATA_LO];
    end else if (hit_wb_s) begin
      fwd = wb_back[BACK_DATA_HI:BACK_DATA_LO];
    end else begin
      fwd = rd;
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: single-cycle multiply/divide unit holding the HI/LO registers.
//   clk, rst      : clock, asynchronous active-low reset (clears HI/LO)
//   a, b          : operands
//   md_sign       : 1 = signed MULT/DIV
//   md_func       : operation (see ex_pkg::md_func_e)
//   md_hi, md_lo  : HI/LO register contents
module ex_mdu
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_sign,
  input  logic [2:0]  md_func,
  output logic [31:0] md_hi,
  output logic [31:0] md_lo
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] prod_s;
  md_res_t     div_s;

  // Sign-extending to 64 bits lets one unsigned multiplier serve both modes.
  assign prod_s = {{32{md_sign & a[31]}}, a} * {{32{md_sign & b[31]}}, b};
  assign div_s  = div_op(a, b, md_sign);

  // Next-state selection for HI/LO; unlisted functions hold.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    case (md_func)
      MD_MULT: begin
        hi_d = prod_s[63:32];
        lo_d = prod_s[31:0];
      end
      MD_DIV: begin
        hi_d = div_s.hi;
        lo_d = div_s.lo;
      end
      MD_MTHI: hi_d = a;
      MD_MTLO: lo_d = a;
      default: begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    endcase
  end

  // HI/LO state; reset clears immediately and drops any in-flight issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign md_hi = hi_q;
  assign md_lo = lo_q;

endmodule

// File: rtl/ex_exec_unit.sv
// ex_exec_unit: execute stage wrapper.
//   clk, rst                 : clock, asynchronous active-low reset
//   rd1, rd2, rs, rt         : register-file data and source numbers
//   mem_back, wb_back        : bypass buses {we, rw, data}, with use_* enables
//   ext_imm, alu_src         : immediate and B-operand select
//   aluop, sa                : ALU function and shift amount
//   md_sign, md_func         : HI/LO unit control
//   f_rd1, f_rd2             : forwarded operands
//   alu_c, zero              : ALU result and zero flag
//   md_hi, md_lo             : HI/LO registers
module ex_exec_unit
  import ex_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       rd1,
  input  logic [31:0]       rd2,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [BACK_W-1:0] mem_back,
  input  logic [BACK_W-1:0] wb_back,
  input  logic              use_mem_back,
  input  logic              use_wb_back,
  input  logic [31:0]       ext_imm,
  input  logic              alu_src,
  input  logic [3:0]        aluop,
  input  logic [4:0]        sa,
  input  logic              md_sign,
  input  logic [2:0]        md_func,
  output logic [31:0]       f_rd1,
  output logic [31:0]       f_rd2,
  output logic [31:0]       alu_c,
  output logic              zero,
  output logic [31:0]       md_hi,
  output logic [31:0]       md_lo
);

  logic [31:0] alu_b_s;

  ex_forward u_fwd_rs (
    .reg_num  (rs),
    .rd       (rd1),
    .mem_back (mem_back),
    .use_mem  (use_mem_back),
    .wb_back  (wb_back),
    .use_wb   (use_wb_back),
    .fwd      (f_rd1)
  );

  ex_forward u_fwd_rt (
    .reg_num  (rt),
    .rd       (rd2),
    .mem_back (mem_back),
    .use_mem  (use_mem_back),
    .wb_back  (wb_back),
    .use_wb   (use_wb_back),
    .fwd      (f_rd2)
  );

  assign alu_b_s = alu_src ? ext_imm : f_rd2;

  ex_alu u_alu (
    .a     (f_rd1),
    .b     (alu_b_s),
    .sa    (sa),
    .aluop (aluop),
    .c     (alu_c),
    .zero  (zero)
  );

  ex_mdu u_mdu (
    .clk     (clk),
    .rst     (rst),
    .a       (f_rd1),
    .b       (alu_b_s),
    .md_sign (md_sign),
    .md_func (md_func),
    .md_hi   (md_hi),
    .md_lo   (md_lo)
  );

endmodule

// File: tb/tb_ex_exec_unit.sv
module tb_ex_exec_unit;

  logic        clk;
  logic        rst;
  logic [31:0] rd1, rd2;
  logic [4:0]  rs, rt;
  logic [37:0] mem_back, wb_back;
  logic        use_mem_back, use_wb_back;
  logic [31:0] ext_imm;
  logic        alu_src;
  logic [3:0]  aluop;
  logic [4:0]  sa;
  logic        md_sign;
  logic [2:0]  md_func;
  logic [31:0] f_rd1, f_rd2, alu_c, md_hi, md_lo;
  logic        zero;

  int tests_run;
  int tests_failed;

  ex_exec_unit dut (
    .clk          (clk),
    .rst          (rst),
    .rd1          (rd1),
    .rd2          (rd2),
    .rs           (rs),
    .rt           (rt),
    .mem_back     (mem_back),
    .wb_back      (wb_back),
    .use_mem_back (use_mem_back),
    .use_wb_back  (use_wb_back),
    .ext_imm      (ext_imm),
    .alu_src      (alu_src),
    .aluop        (aluop),
    .sa           (sa),
    .md_sign      (md_sign),
    .md_func      (md_func),
    .f_rd1        (f_rd1),
    .f_rd2        (f_rd2),
    .alu_c        (alu_c),
    .zero         (zero),
    .md_hi        (md_hi),
    .md_lo        (md_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive A through rd1 and B through rd2 with no forwarding active.
  task automatic set_ab(input logic [31:0] a, input logic [31:0] b);
    use_mem_back = 1'b0;
    use_wb_back  = 1'b0;
    rs      = 5'd0;
    rt      = 5'd0;
    rd1     = a;
    rd2     = b;
    alu_src = 1'b0;
  endtask

  // Issue one HI/LO operation at a negedge; it takes effect on the next posedge.
  task automatic issue_md(input logic [2:0] func, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    set_ab(a, b);
    md_sign = sgn;
    md_func = func;
    @(posedge clk);
    #1;
    md_func = 3'd0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b0;
    rd1 = 32'd0; rd2 = 32'd0; rs = 5'd0; rt = 5'd0;
    mem_back = 38'd0; wb_back = 38'd0;
    use_mem_back = 1'b0; use_wb_back = 1'b0;
    ext_imm = 32'd0; alu_src = 1'b0; aluop = 4'd0; sa = 5'd0;
    md_sign = 1'b0; md_func = 3'd0;
    #1;
    check("reset_hi", md_hi, 32'd0);
    check("reset_lo", md_lo, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Forwarding
    rs = 5'd5; rd1 = 32'd1; rt = 5'd3; rd2 = 32'h22;
    mem_back = {1'b1, 5'd5, 32'h0000_00AA};
    wb_back  = {1'b1, 5'd5, 32'h0000_00BB};
    use_mem_back = 1'b1; use_wb_back = 1'b1;
    #1 check("fwd_mem_prio", f_rd1, 32'hAA);
    check("fwd_rt_nomatch", f_rd2, 32'h22);
    mem_back = {1'b0, 5'd5, 32'h0000_00AA};
    #1 check("fwd_wb_mem_we0", f_rd1, 32'hBB);
    mem_back = {1'b1, 5'd5, 32'h0000_00AA};
    use_mem_back = 1'b0;
    #1 check("fwd_wb_mem_unused", f_rd1, 32'hBB);
    rt = 5'd5; use_wb_back = 1'b0;
    #1 check("fwd_rt_none", f_rd2, 32'h22);
    use_wb_back = 1'b1;
    #1 check("fwd_rt_wb", f_rd2, 32'hBB);
    rs = 5'd0; use_mem_back = 1'b1;
    mem_back = {1'b1, 5'd0, 32'h0000_00AA};
    wb_back  = {1'b1, 5'd0, 32'h0000_00BB};
    #1 check("fwd_r0", f_rd1, 32'd1);

    // ALU
    set_ab(32'h7FFF_FFFF, 32'd1); aluop = 4'd0;
    #1 check("add_wrap", alu_c, 32'h8000_0000);
    check("add_zero", {31'd0, zero}, 32'd0);
    set_ab(32'd3, 32'd3); aluop = 4'd1;
    #1 check("sub", alu_c, 32'd0);
    check("sub_zero", {31'd0, zero}, 32'd1);
    set_ab(32'hFFFF_FFFF, 32'd1); aluop = 4'd6;
    #1 check("slt", alu_c, 32'd1);
    aluop = 4'd7;
    #1 check("sltu", alu_c, 32'd0);
    set_ab(32'h0F0F_0000, 32'h00F0_00F0); aluop = 4'd5;
    #1 check("nor", alu_c, 32'hF000_FF0F);
    set_ab(32'd0, 32'h8000_0000); aluop = 4'd10; sa = 5'd4;
    #1 check("sra", alu_c, 32'hF800_0000);
    aluop = 4'd9;
    #1 check("srl", alu_c, 32'h0800_0000);
    set_ab(32'd36, 32'h0000_00F0); aluop = 4'd12;
    #1 check("srlv", alu_c, 32'h0000_000F);
    set_ab(32'd0, 32'd0); alu_src = 1'b1; ext_imm = 32'h0000_1234; aluop = 4'd14;
    #1 check("lui", alu_c, 32'h1234_0000);
    aluop = 4'd15;
    #1 check("pass_imm", alu_c, 32'h0000_1234);

    // HI/LO unit
    issue_md(3'd1, 1'b1, 32'hFFFF_FFFE, 32'd3);
    check("mult_s_hi", md_hi, 32'hFFFF_FFFF);
    check("mult_s_lo", md_lo, 32'hFFFF_FFFA);
    issue_md(3'd1, 1'b0, 32'hFFFF_FFFE, 32'd3);
    check("mult_u_hi", md_hi, 32'd2);
    check("mult_u_lo", md_lo, 32'hFFFF_FFFA);
    issue_md(3'd2, 1'b1, 32'hFFFF_FFF9, 32'd2);
    check("div_s_lo", md_lo, 32'hFFFF_FFFD);
    check("div_s_hi", md_hi, 32'hFFFF_FFFF);
    issue_md(3'd2, 1'b0, 32'd7, 32'd2);
    check("div_u_lo", md_lo, 32'd3);
    check("div_u_hi", md_hi, 32'd1);
    issue_md(3'd2, 1'b1, 32'd9, 32'd0);
    check("div0_lo", md_lo, 32'hFFFF_FFFF);
    check("div0_hi", md_hi, 32'd9);
    issue_md(3'd2, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divovf_lo", md_lo, 32'h8000_0000);
    check("divovf_hi", md_hi, 32'd0);
    issue_md(3'd3, 1'b0, 32'h55, 32'd0);
    check("mthi_hi", md_hi, 32'h55);
    check("mthi_lo_hold", md_lo, 32'h8000_0000);
    issue_md(3'd0, 1'b0, 32'h1234, 32'h5678);
    check("none_hi_hold", md_hi, 32'h55);
    issue_md(3'd4, 1'b0, 32'h66, 32'd0);
    check("mtlo_lo", md_lo, 32'h66);

    // Reset mid-cycle with an MTLO pending: cleared at once and issue discarded
    @(negedge clk);
    set_ab(32'h77, 32'd0);
    md_func = 3'd4;
    #2 rst = 1'b0;
    #1 check("rst_async_hi", md_hi, 32'd0);
    check("rst_async_lo", md_lo, 32'd0);
    @(negedge clk);
    md_func = 3'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("post_rst_hi", md_hi, 32'd0);
    check("post_rst_lo", md_lo, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
